// File: rtl/cache_pkg.sv
// Shared types and helpers for the data cache and its load formatting logic.
package cache_pkg;

  localparam logic [1:0] DT_WORD = 2'b00;
  localparam logic [1:0] DT_BYTE = 2'b01;
  localparam logic [1:0] DT_HALF = 2'b10;

  typedef enum logic {IDLE, FILL} state_t;

  function automatic int tag_width(input int address_width, input int sets);
    return address_width - 2 - $clog2(sets);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half/word of a 32-bit word and sign-extends it.
module load_extend
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [1:0]            dtype,
  input  logic [1:0]            offset,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_s = word[{offset, 3'b000} +: 8];
    half_s = word[{offset[1], 4'b0000} +: 16];
    rdata  = '0;
    case (dtype)
      DT_WORD: rdata = word;
      DT_BYTE: rdata = DATA_WIDTH'(byte_s);
      DT_HALF: rdata = DATA_WIDTH'(half_s);
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache, one word per line.
module data_cache
  import cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 17,
  parameter int DATA_WIDTH    = 32,
  parameter int SETS          = 8,
  parameter int MEM_LATENCY   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_re,
  input  logic                     cpu_we,
  input  logic [1:0]               cpu_dtype,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     stall,
  output logic                     mem_we,
  output logic [1:0]               mem_dtype,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic [31:0]              hit_cnt,
  output logic [31:0]              miss_cnt
);

  localparam int IW = $clog2(SETS);
  localparam int TW = tag_width(ADDRESS_WIDTH, SETS);
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  logic [SETS-1:0]       valid_q, valid_d;
  logic [TW-1:0]         tag_arr  [SETS];
  logic [DATA_WIDTH-1:0] data_arr [SETS];

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:2] line_addr_q, line_addr_d;
  logic                     filled_q, filled_d;
  logic [31:0]              hit_cnt_q, hit_cnt_d;
  logic [31:0]              miss_cnt_q, miss_cnt_d;

  logic [IW-1:0]         idx;
  logic [TW-1:0]         tag;
  logic [1:0]            off;
  logic                  legal, is_store, is_load, hit;
  logic [DATA_WIDTH-1:0] wr_word;
  logic                  arr_we;
  logic [IW-1:0]         arr_idx;
  logic [TW-1:0]         arr_tag;
  logic [DATA_WIDTH-1:0] arr_data;

  assign idx      = cpu_addr[2+IW-1:2];
  assign tag      = cpu_addr[ADDRESS_WIDTH-1:2+IW];
  assign off      = cpu_addr[1:0];
  assign legal    = (cpu_dtype != 2'b11);
  assign is_store = cpu_we & legal;
  assign is_load  = cpu_re & ~cpu_we & legal;
  assign hit      = valid_q[idx] && (tag_arr[idx] == tag);

  // Store-hit merge of the narrow write data into the cached word
  always_comb begin
    wr_word = data_arr[idx];
    case (cpu_dtype)
      DT_WORD: wr_word = cpu_wdata;
      DT_BYTE: wr_word[{off, 3'b000} +: 8] = cpu_wdata[7:0];
      DT_HALF: wr_word[{off[1], 4'b0000} +: 16] = cpu_wdata[15:0];
      default: wr_word = data_arr[idx];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_addr_d = line_addr_q;
    filled_d    = 1'b0;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    valid_d     = valid_q;
    arr_we      = 1'b0;
    arr_idx     = idx;
    arr_tag     = tag;
    arr_data    = wr_word;
    stall       = 1'b0;
    mem_we      = 1'b0;
    mem_dtype   = cpu_dtype;
    mem_addr    = cpu_addr;
    mem_wdata   = cpu_wdata;
    case (state_q)
      IDLE: begin
        if (is_store) begin
          mem_we = 1'b1;
          arr_we = hit;
        end else if (is_load) begin
          if (hit) begin
            // The completing cycle of a miss is not a genuine hit
            if (!filled_q) hit_cnt_d = hit_cnt_q + 32'd1;
          end else begin
            stall       = 1'b1;
            miss_cnt_d  = miss_cnt_q + 32'd1;
            mem_dtype   = DT_WORD;
            mem_addr    = {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
            line_addr_d = cpu_addr[ADDRESS_WIDTH-1:2];
            cnt_d       = CW'(MEM_LATENCY - 1);
            state_d     = FILL;
          end
        end
      end
      FILL: begin
        stall     = 1'b1;
        mem_dtype = DT_WORD;
        mem_addr  = {line_addr_q, 2'b00};
        if (cnt_q == '0) begin
          arr_we   = 1'b1;
          arr_idx  = line_addr_q[2+IW-1:2];
          arr_tag  = line_addr_q[ADDRESS_WIDTH-1:2+IW];
          arr_data = mem_rdata;
          filled_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      stall  = 1'b0;
      mem_we = 1'b0;
      arr_we = 1'b0;
    end
    if (arr_we) valid_d[arr_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      valid_q    <= '0;
      filled_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      filled_q   <= filled_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    line_addr_q <= line_addr_d;
    if (arr_we) begin
      tag_arr[arr_idx]  <= arr_tag;
      data_arr[arr_idx] <= arr_data;
    end
  end

  load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
    .word   (data_arr[idx]),
    .dtype  (cpu_dtype),
    .offset (off),
    .rdata  (cpu_rdata)
  );

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule
